tt_um_moving_average: RTL and testbench
=======================================

TT_UM_MOVING_AVERAGE -- requirements
Module: tt_um_moving_average

Interface
REQ-001 Parameter: none; window length is fixed at N = 8 samples and sample width at 10 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  block enable; high = normal operation.
REQ-005 ui_in  input  8  sample bits [7:0].
REQ-006 uio_in  input  8  [0] = sample strobe, [3:2] = sample bits [9:8]; other bits ignored.
REQ-007 uo_out  output  8  average bits [7:0].
REQ-008 uio_out  output  8  [1] = avg_valid pulse, [5:4] = average bits [9:8]; all other bits 0.
REQ-009 uio_oe  output  8  constant 8'b0011_0010 (bits 1, 4, 5 driven; 0, 2, 3, 6, 7 inputs).

Function
REQ-010 Sample word SHALL be {uio_in[3:2], ui_in[7:0]}, unsigned 10-bit (0..1023).
REQ-011 Strobe is edge-qualified: a registered copy strobe_q of uio_in[0] is kept; a sample is accepted on a rising clk edge where uio_in[0]=1, strobe_q=0, ena=1 and rst_n=1.
REQ-012 Holding the strobe high for several cycles SHALL accept exactly one sample; the strobe must return low for at least one cycle before the next acceptance.
REQ-013 Window storage: 8-entry circular buffer of 10-bit samples with a 3-bit write pointer; on acceptance the new sample overwrites the entry at the pointer and the pointer increments modulo 8 (7 wraps to 0).
REQ-014 Running sum: 13-bit unsigned register; on acceptance sum_next = sum + new_sample - buffer[ptr] (the overwritten oldest entry); no overflow is possible (max 8*1023 = 8184).
REQ-015 Average SHALL be sum_next[12:3] (divide by 8, truncate toward zero), registered on the accepting edge; output latency is one cycle (visible after the edge that accepts the sample).
REQ-016 Divisor is always 8: before 8 samples have been accepted since reset, empty slots count as zero.
REQ-017 avg_valid (uio_out[1]) SHALL be high for exactly one cycle following each accepting edge, otherwise low.
REQ-018 Average output SHALL hold its value between acceptances.
REQ-019 When ena=0, no sample is accepted and all state (buffer, pointer, sum, average) holds; strobe_q still tracks uio_in[0]; avg_valid is 0.
REQ-020 Unused uio_out bits and uio_in bits other than 0, 2, 3 have no effect on function.

Reset
REQ-021 While rst_n=0 at a rising edge: buffer entries, pointer, sum, average register, avg_valid and strobe_q SHALL all be cleared to 0; uo_out=0, uio_out=0.
REQ-022 Reset SHALL take priority over a simultaneous strobe; a sample presented during the reset cycle is discarded.
REQ-023 Reset asserted mid-stream SHALL discard the whole window; the next accepted sample S yields average S>>3.
REQ-024 uio_oe is constant and unaffected by reset.

Verification
REQ-025 After reset, one strobe pulse with sample 800 -> next cycle uo_out=100, uio_out[5:4]=0, uio_out[1]=1 for one cycle.
REQ-026 Ramp: samples 0,1,2,...,999 each with a one-cycle strobe pulse followed by one low cycle -> after sample 7 average=3; after sample i (i>=7) average=i-4 (e.g. i=999 -> 995 = uio_out[5:4]=3, uo_out=0xE3); wraps cleanly every 8 samples.
REQ-027 Eight samples of 1023 -> average 1023 (uo_out=0xFF, uio_out[5:4]=3); then eight samples of 0 -> average steps down 895, 767, ..., 0.
REQ-028 Strobe held high 5 cycles with sample 64 -> exactly one acceptance, average 8, single avg_valid pulse.
REQ-029 Strobe pulse with ena=0 -> no change in average, no avg_valid; same pulse with ena=1 -> accepted.
REQ-030 Fill window with 400, assert rst_n=0 for one cycle -> outputs 0; then sample 16 -> average 2.

Source files
------------

// File: rtl/tt_um_moving_average.sv
// Eight-sample moving average of 10-bit samples, accepted on rising edges of a strobe.
// Running sum is updated incrementally; the average is sum/8 with empty slots counting as zero.
module tt_um_moving_average (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned Depth = 8;

  logic [9:0]  sample;
  logic        accept;

  logic        strobe_q, strobe_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [12:0] sum_q, sum_d;
  logic [9:0]  avg_q, avg_d;
  logic        valid_q, valid_d;
  logic [9:0]  win_q [Depth];
  logic [9:0]  win_d [Depth];

  logic        unused_bits;

  assign unused_bits = ^{uio_in[7:4], uio_in[1]};

  always_comb begin
    sample = {uio_in[3:2], ui_in};
    // Edge-qualified strobe: only the low-to-high transition accepts a sample.
    accept = ena & uio_in[0] & ~strobe_q;

    strobe_d = uio_in[0];
    ptr_d    = ptr_q;
    sum_d    = sum_q;
    avg_d    = avg_q;
    valid_d  = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      win_d[i] = win_q[i];
    end

    if (accept) begin
      win_d[ptr_q] = sample;
      ptr_d        = ptr_q + 3'd1;
      sum_d        = sum_q + {3'b000, sample} - {3'b000, win_q[ptr_q]};
      avg_d        = sum_d[12:3];
      valid_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      ptr_q    <= '0;
      sum_q    <= '0;
      avg_q    <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      strobe_q <= strobe_d;
      ptr_q    <= ptr_d;
      sum_q    <= sum_d;
      avg_q    <= avg_d;
      valid_q  <= valid_d;
      for (int i = 0; i < Depth; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  always_comb begin
    uo_out  = avg_q[7:0];
    uio_out = {2'b00, avg_q[9:8], 2'b00, valid_q, 1'b0};
    uio_oe  = 8'b0011_0010;
  end

endmodule

// File: tb/tb_tt_um_moving_average.sv
// Scoreboard bench for tt_um_moving_average: stimulus pushes hand-computed averages,
// a monitor pops one per avg_valid pulse and compares.
module tb_tt_um_moving_average;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [9:0]  exp_q [$];

  tt_um_moving_average dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Drive sample and strobe; unused uio_in bits get random junk.
  task automatic drive(input logic [9:0] s, input logic stb);
    logic [31:0] r;
    r = $urandom;
    ui_in  = s[7:0];
    uio_in = {r[7:4], s[9:8], r[1], stb};
  endtask

  // One-cycle strobe pulse followed by one low cycle.
  task automatic send(input logic [9:0] s, input logic [9:0] want);
    @(negedge clk);
    drive(s, 1'b1);
    exp_q.push_back(want);
    @(negedge clk);
    drive(s, 1'b0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    drive(10'd0, 1'b0);
    @(negedge clk);
    check({name, "_uo_out"}, int'(uo_out), 0);
    check({name, "_uio_out"}, int'(uio_out), 0);
    rst_n = 1'b1;
  endtask

  // Monitor: every avg_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (uio_out[1]) begin
      check("reserved_uio_out_bits", int'(uio_out & 8'hCD), 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got avg %0d, expected no pulse",
                 {uio_out[5:4], uo_out});
      end else begin
        check("average", int'({uio_out[5:4], uo_out}), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    repeat (2) @(negedge clk);
    do_reset("reset");
    check("uio_oe", int'(uio_oe), 8'h32);

    // Sample presented during reset is discarded.
    @(negedge clk);
    rst_n = 1'b0;
    drive(10'd500, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(10'd500, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_priority_avg", int'({uio_out[5:4], uo_out}), 0);

    // Single sample 800 -> 100.
    send(10'd800, 10'd100);
    repeat (2) @(negedge clk);
    check("hold_after_800", int'({uio_out[5:4], uo_out}), 100);

    // Strobe held five cycles -> one acceptance.
    do_reset("reset_hold");
    @(negedge clk);
    drive(10'd64, 1'b1);
    exp_q.push_back(10'd8);
    repeat (4) begin
      @(negedge clk);
      drive(10'd64, 1'b1);
    end
    @(negedge clk);
    drive(10'd64, 1'b0);
    repeat (2) @(negedge clk);

    // ena=0 pulse is ignored, ena=1 pulse accepted: window {64,80} -> 18.
    @(negedge clk);
    ena = 1'b0;
    drive(10'd80, 1'b1);
    @(negedge clk);
    drive(10'd80, 1'b0);
    @(negedge clk);
    check("ena_low_hold", int'({uio_out[5:4], uo_out}), 8);
    ena = 1'b1;
    send(10'd80, 10'd18);

    // Full scale then drain.
    do_reset("reset_full");
    for (int k = 1; k <= 8; k++) send(10'd1023, 10'((k * 1023) >> 3));
    for (int k = 1; k <= 8; k++) send(10'd0, 10'(((8 - k) * 1023) >> 3));

    // Fill with 400, reset mid-stream, then 16 -> 2.
    do_reset("reset_fill");
    for (int k = 1; k <= 8; k++) send(10'd400, 10'(k * 50));
    do_reset("reset_mid");
    send(10'd16, 10'd2);

    // Ramp 0..999.
    do_reset("reset_ramp");
    for (int i = 0; i < 1000; i++) begin
      if (i <= 7) send(10'(i), 10'((i * (i + 1) / 2) >> 3));
      else send(10'(i), 10'(i - 4));
    end
    repeat (3) @(negedge clk);
    check("ramp_final_uo_out", int'(uo_out), 8'hE3);
    check("ramp_final_hi", int'(uio_out[5:4]), 3);
    check("pending_expectations", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
